// File: rtl/seqdet_pkg.sv
// Shared types and default sizing for the round-robin shared "101" detector.
package seqdet_pkg;

    localparam int unsigned DefNreq = 4;
    localparam int unsigned DefDw   = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DetS0 = 2'd0,
        DetS1 = 2'd1,
        DetS2 = 2'd2
    } det_state_e;

endpackage

// File: rtl/seqdet_core.sv
// Bit-serial overlapping "101" Mealy detector; advances on en_i, clr_i returns it to S0.
module seqdet_core
    import seqdet_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    input  logic x_i,
    output logic hit_o
);

    det_state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = DetS0;
        end else if (en_i) begin
            unique case (state_q)
                DetS0:   state_d = x_i ? DetS1 : DetS0;
                DetS1:   state_d = x_i ? DetS1 : DetS2;
                DetS2:   state_d = x_i ? DetS1 : DetS0;
                default: state_d = DetS0;
            endcase
        end
    end

    assign hit_o = (state_q == DetS2) && x_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DetS0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/seqdet_arbiter.sv
// Round-robin arbiter sharing one serial "101" detector between NREQ byte-wide requesters.
module seqdet_arbiter
    import seqdet_pkg::*;
#(
    parameter int unsigned NREQ = DefNreq,
    parameter int unsigned DW   = DefDw,
    localparam int unsigned CW  = $clog2(DW),
    localparam int unsigned IdW = $clog2(NREQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*DW-1:0]   data_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [IdW-1:0]       done_id_o,
    output logic [CW-1:0]        match_cnt_o
);

    state_e          state_q, state_d;
    logic [IdW-1:0]  ptr_q, ptr_d;
    logic [IdW-1:0]  id_q, id_d;
    logic [DW-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]   bitcnt_q, bitcnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            pick_valid;
    logic [IdW-1:0]  pick_sel;
    logic [IdW-1:0]  cand;
    logic            det_clr, det_en, det_hit;
    logic [DW-1:0]   words [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign words[g] = data_i[g*DW +: DW];
    end

    // First requester at or after ptr+1, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick_sel   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IdW'((32'(ptr_q) + k) % NREQ);
            if (!pick_valid && req_i[cand]) begin
                pick_valid = 1'b1;
                pick_sel   = cand;
            end
        end
    end

    seqdet_core u_core (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (det_clr),
        .en_i   (det_en),
        .x_i    (shreg_q[0]),
        .hit_o  (det_hit)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        busy_d   = busy_q;
        done_d   = done_q;
        det_clr  = 1'b0;
        det_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d    = NREQ'(1) << pick_sel;
                    shreg_d  = words[pick_sel];
                    id_d     = pick_sel;
                    bitcnt_d = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    det_clr  = 1'b1;
                    state_d  = StShift;
                end
            end
            StShift: begin
                det_en   = 1'b1;
                shreg_d  = shreg_q >> 1;
                bitcnt_d = bitcnt_q + CW'(1);
                if (det_hit) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (bitcnt_q == CW'(DW - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Two cycles here: one to raise done, one to drop done and busy together.
                if (!done_q) begin
                    done_d = 1'b1;
                    ptr_d  = id_q;
                end else begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            ptr_q    <= IdW'(NREQ - 1);
            id_q     <= '0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign done_id_o   = id_q;
    assign match_cnt_o = cnt_q;

endmodule
